// File: rtl/sram_ctrl_if.sv
// Host request/response, fill control and SRAM pin bundle for sram_ctrl.
interface sram_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [11:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       init_start;
  logic       busy;
  logic       init_done;
  logic       CS;
  logic       RW;
  logic [5:0] Address_Row;
  logic [5:0] Address_Col;
  logic [7:0] data_in;
  logic [7:0] sram_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, init_start, sram_rdata,
    output req_ready, rsp_valid, rsp_rdata, busy, init_done,
           CS, RW, Address_Row, Address_Col, data_in
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, init_start, sram_rdata,
    input  req_ready, rsp_valid, rsp_rdata, busy, init_done,
           CS, RW, Address_Row, Address_Col, data_in
  );
endinterface

// File: rtl/sram_ctrl.sv
// SRAM controller: runs each host access or zero-fill location through a
// SETUP / ACCESS / HOLD cycle on a 4096x8 asynchronous SRAM.
module sram_ctrl #(
  parameter int unsigned ACCESS_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  sram_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_e;

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYC - 1);

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        init_active_q;
  logic [11:0] init_addr_q;
  logic [11:0] init_addr_d;
  logic        cs_q;
  logic        rw_q;
  logic [5:0]  row_q;
  logic [5:0]  col_q;
  logic [7:0]  data_in_q;
  logic        rsp_valid_q;
  logic [7:0]  rsp_rdata_q;
  logic        init_done_q;

  assign init_addr_d = init_addr_q + 12'd1;

  // NOTE: all state below uses non-blocking assignments so every branch sees
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      init_active_q <= 1'b0;
      init_addr_q   <= '0;
      cs_q          <= 1'b1;
      rw_q          <= 1'b1;
      row_q         <= '0;
      col_q         <= '0;
      data_in_q     <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      init_done_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      init_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.init_start && !init_active_q) begin
            init_active_q <= 1'b1;
            init_addr_q   <= '0;
            row_q         <= '0;
            col_q         <= '0;
            rw_q          <= 1'b0;
            data_in_q     <= '0;
            state_q       <= SETUP;
          end else if (init_active_q) begin
            row_q     <= init_addr_q[11:6];
            col_q     <= init_addr_q[5:0];
            rw_q      <= 1'b0;
            data_in_q <= '0;
            state_q   <= SETUP;
          end else if (bus.req_valid) begin
            // init_start is low here, so this is exactly a req_ready handshake.
            row_q     <= bus.req_addr[11:6];
            col_q     <= bus.req_addr[5:0];
            rw_q      <= !bus.req_we;
            data_in_q <= bus.req_wdata;
            state_q   <= SETUP;
          end
        end
        SETUP: begin
          cs_q    <= 1'b0;
          cnt_q   <= CNT_LOAD;
          state_q <= ACCESS;
        end
        ACCESS: begin
          if (cnt_q == 4'd0) begin
            cs_q    <= 1'b1;
            state_q <= HOLD;
            if (rw_q) begin
              rsp_rdata_q <= bus.sram_rdata;
              rsp_valid_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        HOLD: begin
          state_q <= IDLE;
          if (init_active_q) begin
            // Stop on the last location instead of letting the counter wrap.
            if (init_addr_q == 12'hFFF) begin
              init_active_q <= 1'b0;
              init_done_q   <= 1'b1;
            end else begin
              init_addr_q <= init_addr_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready   = (state_q == IDLE) && !bus.init_start && !init_active_q;
  assign bus.busy        = (state_q != IDLE) || init_active_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.init_done   = init_done_q;
  assign bus.CS          = cs_q;
  assign bus.RW          = rw_q;
  assign bus.Address_Row = row_q;
  assign bus.Address_Col = col_q;
  assign bus.data_in     = data_in_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: three instances (ACCESS_CYC = 1, 2, 15), each
// with a behavioural SRAM and a CS-window / bus-stability monitor.
module tb_sram_ctrl;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ac_of(input int idx);
    return (idx == 0) ? 1 : (idx == 1) ? 2 : 15;
  endfunction

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : gen_dut
      sram_ctrl_if ifc ();
      sram_ctrl #(.ACCESS_CYC(ac_of(g))) dut (.clk(clk), .rst(rst), .bus(ifc));

      logic [7:0] mem [4096];
      always @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < 4096; i++) mem[i] <= 8'hEE;
        end else if (!ifc.CS && !ifc.RW) begin
          mem[{ifc.Address_Row, ifc.Address_Col}] <= ifc.data_in;
        end
      end
      assign ifc.sram_rdata = mem[{ifc.Address_Row, ifc.Address_Col}];

      int          win_cnt  = 0;
      int          last_len = 0;
      int          bad_len  = 0;
      int          unstable = 0;
      int          rv_cnt   = 0;
      int          done_cnt = 0;
      int          run      = 0;
      logic        cs_prev  = 1'b1;
      logic        rst_edge = 1'b1;
      logic [20:0] prev     = '0;
      logic [20:0] cur;
      assign cur = {ifc.Address_Row, ifc.Address_Col, ifc.RW, ifc.data_in};

      always @(posedge clk) rst_edge <= rst;

      always @(negedge clk) begin
        if (!ifc.CS) begin
          run <= run + 1;
        end else begin
          if (!cs_prev) begin
            win_cnt  <= win_cnt + 1;
            last_len <= run;
            if (run != ac_of(g)) bad_len <= bad_len + 1;
          end
          run <= 0;
        end
        if (!rst_edge && (!ifc.CS || !cs_prev) && (cur != prev)) unstable <= unstable + 1;
        if (ifc.rsp_valid) rv_cnt <= rv_cnt + 1;
        if (ifc.init_done) done_cnt <= done_cnt + 1;
        prev    <= cur;
        cs_prev <= ifc.CS;
      end
    end
  endgenerate

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drives a request on the ACCESS_CYC=2 instance; returns at handshake edge + 1.
  task automatic req1(input logic we, input logic [11:0] a, input logic [7:0] d);
    int k;
    gen_dut[1].ifc.req_we    = we;
    gen_dut[1].ifc.req_addr  = a;
    gen_dut[1].ifc.req_wdata = d;
    gen_dut[1].ifc.req_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!gen_dut[1].ifc.req_ready && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 1000) check("handshake_timeout", 32'(k), 32'd0);
    @(posedge clk);
    #1 gen_dut[1].ifc.req_valid = 1'b0;
  endtask

  task automatic wait_idle1();
    int k;
    k = 0;
    @(negedge clk);
    while (gen_dut[1].ifc.busy && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 1000) check("idle_timeout", 32'(k), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp1(output int lat, output logic [7:0] data, output logic [11:0] haddr);
    lat   = 0;
    data  = 'x;
    haddr = 'x;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (gen_dut[1].ifc.rsp_valid) begin
        lat   = n;
        data  = gen_dut[1].ifc.rsp_rdata;
        haddr = {gen_dut[1].ifc.Address_Row, gen_dut[1].ifc.Address_Col};
        break;
      end
    end
  endtask

  task automatic read1(input logic [11:0] a, output int lat, output logic [7:0] data,
                       output logic [11:0] haddr);
    req1(1'b0, a, 8'h00);
    wait_rsp1(lat, data, haddr);
    wait_idle1();
  endtask

  int          lat, lat0, lat2, done_n, early, wc0, rv0, idle_k;
  logic [7:0]  d, d0, d2;
  logic [11:0] ha;

  initial begin
    rst = 1'b1;
    gen_dut[0].ifc.req_valid = 1'b0; gen_dut[0].ifc.req_we = 1'b0; gen_dut[0].ifc.init_start = 1'b0;
    gen_dut[0].ifc.req_addr  = '0;   gen_dut[0].ifc.req_wdata = '0;
    gen_dut[1].ifc.req_valid = 1'b0; gen_dut[1].ifc.req_we = 1'b0; gen_dut[1].ifc.init_start = 1'b0;
    gen_dut[1].ifc.req_addr  = '0;   gen_dut[1].ifc.req_wdata = '0;
    gen_dut[2].ifc.req_valid = 1'b0; gen_dut[2].ifc.req_we = 1'b0; gen_dut[2].ifc.init_start = 1'b0;
    gen_dut[2].ifc.req_addr  = '0;   gen_dut[2].ifc.req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cs",        32'(gen_dut[1].ifc.CS), 32'd1);
    check("rst_rw",        32'(gen_dut[1].ifc.RW), 32'd1);
    check("rst_addr",      32'({gen_dut[1].ifc.Address_Row, gen_dut[1].ifc.Address_Col}), 32'd0);
    check("rst_data_in",   32'(gen_dut[1].ifc.data_in), 32'd0);
    check("rst_rsp_valid", 32'(gen_dut[1].ifc.rsp_valid), 32'd0);
    check("rst_rsp_rdata", 32'(gen_dut[1].ifc.rsp_rdata), 32'd0);
    check("rst_busy",      32'(gen_dut[1].ifc.busy), 32'd0);
    check("rst_init_done", 32'(gen_dut[1].ifc.init_done), 32'd0);
    check("rst_req_ready", 32'(gen_dut[1].ifc.req_ready), 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;

    // ACCESS_CYC = 1 and 15 in lockstep: write 0x5A to 0x123, then read it back.
    for (int pass = 0; pass < 2; pass++) begin
      gen_dut[0].ifc.req_we = (pass == 0); gen_dut[0].ifc.req_addr = 12'h123;
      gen_dut[0].ifc.req_wdata = 8'h5A;    gen_dut[0].ifc.req_valid = 1'b1;
      gen_dut[2].ifc.req_we = (pass == 0); gen_dut[2].ifc.req_addr = 12'h123;
      gen_dut[2].ifc.req_wdata = 8'h5A;    gen_dut[2].ifc.req_valid = 1'b1;
      @(negedge clk);
      check("ac1_ready",  32'(gen_dut[0].ifc.req_ready), 32'd1);
      check("ac15_ready", 32'(gen_dut[2].ifc.req_ready), 32'd1);
      @(posedge clk);
      #1;
      gen_dut[0].ifc.req_valid = 1'b0;
      gen_dut[2].ifc.req_valid = 1'b0;
      lat0 = 0; lat2 = 0; d0 = 'x; d2 = 'x;
      for (int n = 1; n <= 40; n++) begin
        @(negedge clk);
        if (gen_dut[0].ifc.rsp_valid && lat0 == 0) begin lat0 = n; d0 = gen_dut[0].ifc.rsp_rdata; end
        if (gen_dut[2].ifc.rsp_valid && lat2 == 0) begin lat2 = n; d2 = gen_dut[2].ifc.rsp_rdata; end
        if (!gen_dut[0].ifc.busy && !gen_dut[2].ifc.busy) break;
      end
      check("ac1_busy_end",  32'(gen_dut[0].ifc.busy), 32'd0);
      check("ac15_busy_end", 32'(gen_dut[2].ifc.busy), 32'd0);
      @(posedge clk);
      #1;
    end
    check("ac1_read_latency",  32'(lat0), 32'd3);
    check("ac15_read_latency", 32'(lat2), 32'd17);
    check("ac1_rdata",         32'(d0), 32'h5A);
    check("ac15_rdata",        32'(d2), 32'h5A);
    check("ac1_cs_len",        32'(gen_dut[0].last_len), 32'd1);
    check("ac15_cs_len",       32'(gen_dut[2].last_len), 32'd15);
    check("ac1_windows",       32'(gen_dut[0].win_cnt), 32'd2);
    check("ac15_windows",      32'(gen_dut[2].win_cnt), 32'd2);
    check("ac1_bad_len",       32'(gen_dut[0].bad_len), 32'd0);
    check("ac15_bad_len",      32'(gen_dut[2].bad_len), 32'd0);
    check("ac1_unstable",      32'(gen_dut[0].unstable), 32'd0);
    check("ac15_unstable",     32'(gen_dut[2].unstable), 32'd0);
    check("ac1_rsp_count",     32'(gen_dut[0].rv_cnt), 32'd1);
    check("ac15_rsp_count",    32'(gen_dut[2].rv_cnt), 32'd1);

    // ACCESS_CYC = 2: write then read 0x041.
    req1(1'b1, 12'h041, 8'hA5);
    wait_idle1();
    check("wr_no_rsp_valid", 32'(gen_dut[1].rv_cnt), 32'd0);
    read1(12'h041, lat, d, ha);
    check("rd041_latency", 32'(lat), 32'd4);
    check("rd041_data",    32'(d), 32'hA5);
    check("rd041_row",     32'(ha[11:6]), 32'd1);
    check("rd041_col",     32'(ha[5:0]), 32'd1);
    check("ac2_cs_len",    32'(gen_dut[1].last_len), 32'd2);
    req1(1'b1, 12'h7FF, 8'h3C);
    wait_idle1();
    check("wr_rdata_held", 32'(gen_dut[1].ifc.rsp_rdata), 32'hA5);
    check("wr_rsp_count",  32'(gen_dut[1].rv_cnt), 32'd1);
    read1(12'h7FF, lat, d, ha);
    check("rd7ff_data",    32'(d), 32'h3C);

    // Fill with a simultaneous read request of 0x7FF held by the host.
    wc0 = gen_dut[1].win_cnt;
    gen_dut[1].ifc.init_start = 1'b1;
    gen_dut[1].ifc.req_we     = 1'b0;
    gen_dut[1].ifc.req_addr   = 12'h7FF;
    gen_dut[1].ifc.req_valid  = 1'b1;
    @(negedge clk);
    check("init_wins_ready", 32'(gen_dut[1].ifc.req_ready), 32'd0);
    @(posedge clk);
    #1 gen_dut[1].ifc.init_start = 1'b0;
    done_n = 0;
    early  = 0;
    for (int n = 1; n <= 30000; n++) begin
      @(negedge clk);
      gen_dut[1].ifc.init_start = (n == 200);
      if (gen_dut[1].ifc.init_done) begin
        done_n = n;
        break;
      end
      if (gen_dut[1].ifc.req_ready || !gen_dut[1].ifc.busy) early++;
    end
    check("init_done_cycle",   32'(done_n), 32'd20480);
    check("init_no_accept",    32'(early), 32'd0);
    check("init_windows",      32'(gen_dut[1].win_cnt - wc0), 32'd4096);
    check("init_done_ready",   32'(gen_dut[1].ifc.req_ready), 32'd1);
    @(posedge clk);
    #1 gen_dut[1].ifc.req_valid = 1'b0;
    wait_rsp1(lat, d, ha);
    wait_idle1();
    check("post_init_latency", 32'(lat), 32'd4);
    check("post_init_rd7ff",   32'(d), 32'h00);
    read1(12'h000, lat, d, ha);
    check("rd000_zero",        32'(d), 32'h00);
    read1(12'hFFF, lat, d, ha);
    check("rdfff_zero",        32'(d), 32'h00);
    check("init_done_pulses",  32'(gen_dut[1].done_cnt), 32'd1);
    check("ac2_bad_len",       32'(gen_dut[1].bad_len), 32'd0);
    check("ac2_unstable",      32'(gen_dut[1].unstable), 32'd0);

    // Reset in the second ACCESS cycle of a read aborts it.
    rv0 = gen_dut[1].rv_cnt;
    req1(1'b0, 12'h041, 8'h00);
    repeat (3) @(negedge clk);
    check("abort_cs_low", 32'(gen_dut[1].ifc.CS), 32'd0);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_cs_high",   32'(gen_dut[1].ifc.CS), 32'd1);
    check("abort_busy",      32'(gen_dut[1].ifc.busy), 32'd0);
    check("abort_rsp_rdata", 32'(gen_dut[1].ifc.rsp_rdata), 32'd0);
    check("abort_ready",     32'(gen_dut[1].ifc.req_ready), 32'd1);
    idle_k = 0;
    repeat (6) begin
      @(negedge clk);
      if (gen_dut[1].ifc.CS !== 1'b1) idle_k++;
    end
    check("abort_cs_stays_high", 32'(idle_k), 32'd0);
    check("abort_no_rsp",        32'(gen_dut[1].rv_cnt - rv0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameter ACCESS_CYC, default 2, meaning the number of cycles CS is held low per access (legal range 1..15).
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  host request present.
REQ-005 req_ready  output  1  controller accepts request this cycle.
REQ-006 req_we  input  1  1 = write, 0 = read.
REQ-007 req_addr  input  12  [11:6] row, [5:0] column.
REQ-008 req_wdata  input  8  write data.
REQ-009 rsp_valid  output  1  one-cycle pulse: read data valid.
REQ-010 rsp_rdata  output  8  registered read data.
REQ-011 init_start  input  1  pulse: zero-fill the whole array.
REQ-012 busy  output  1  high while any access or fill is in progress.
REQ-013 init_done  output  1  one-cycle pulse when the fill completes.
REQ-014 CS  output  1  SRAM chip select, active low.
REQ-015 RW  output  1  SRAM 1 = read, 0 = write.
REQ-016 Address_Row  output  6  SRAM row address.
REQ-017 Address_Col  output  6  SRAM column address.
REQ-018 data_in  output  8  write data driven to the SRAM.
REQ-019 sram_rdata  input  8  SRAM data_out.

Function
REQ-020 All SRAM-side outputs SHALL be registered; the FSM states SHALL be IDLE, SETUP, ACCESS and HOLD.
REQ-021 req_ready SHALL equal (state==IDLE) && !init_start && !init_active.
- A handshake occurs when req_valid && req_ready.
REQ-022 On a handshake, the controller SHALL latch address, write enable and data, then enter SETUP.
REQ-023 SETUP (1 cycle) SHALL drive the address, RW (= !we) and data_in with CS=1.
REQ-024 ACCESS SHALL drive CS=0 for exactly ACCESS_CYC cycles, using a down-counter.
- Address, RW and data_in SHALL be held stable throughout.
REQ-025 For a read, on the last ACCESS edge sram_rdata SHALL be captured into rsp_rdata.
REQ-026 HOLD (1 cycle) SHALL drive CS=1 with address and RW unchanged, then return to IDLE.
- For a read, rsp_valid SHALL be 1 during HOLD only.
REQ-027 Read latency SHALL be ACCESS_CYC+2 cycles from the handshake edge to rsp_valid.
- Maximum throughput SHALL be one access per ACCESS_CYC+3 cycles.
REQ-028 Writes SHALL never assert rsp_valid; rsp_rdata SHALL hold its last value.
REQ-029 RW SHALL change only while CS=1; CS SHALL be 1 in IDLE.
REQ-030 init_start sampled in IDLE SHALL set init_active and begin the fill.
- Each location, 0 to 4095 in increasing order, uses a SETUP/ACCESS/HOLD write of 8'h00.
- The address counter is 12 bits, row = [11:6].
REQ-031 After HOLD of address 4095, init_active SHALL clear, init_done SHALL pulse one cycle, and the FSM SHALL return to IDLE.
- The counter SHALL NOT wrap to issue a 4097th write.
REQ-032 init_start and req_valid in the same IDLE cycle: init wins, the request is not accepted, and req_valid is held by the host.
REQ-033 init_start outside IDLE, or during a fill, SHALL be ignored.
REQ-034 busy SHALL be 1 whenever state!=IDLE or init_active.

Reset
REQ-035 When rst is high at a clock edge, the next state SHALL be:
- state=IDLE, CS=1, RW=1, Address_Row=0, Address_Col=0, data_in=0.
- rsp_valid=0, rsp_rdata=0, init_active=0, init_done=0, busy=0, counters=0.
REQ-036 Reset mid-access or mid-fill SHALL abort the operation: CS=1 at the next edge, no rsp_valid or init_done for the aborted work, and a partial fill is not resumed.

Verification
REQ-037 Write 0xA5 to addr 0x041, then read 0x041 (ACCESS_CYC=2) -> rsp_valid exactly 4 cycles after the read handshake, rsp_rdata=0xA5, row=1, col=1.
REQ-038 Any access -> CS low for exactly ACCESS_CYC cycles; RW and address unchanged from SETUP through HOLD; check with ACCESS_CYC=1 and 15.
REQ-039 init_start, then read 0x000, 0x7FF, 0xFFF -> init_done after 4096*(ACCESS_CYC+3) cycles, all reads return 0x00, exactly 4096 CS-low windows.
REQ-040 init_start and req_valid together in IDLE -> request not accepted until init_done; then it completes normally.
REQ-041 rst asserted in the 2nd ACCESS cycle of a read -> CS=1 next edge, no rsp_valid, req_ready=1 one cycle after reset deasserts.
